// File: rtl/mvm_packet_injector.sv
`default_nettype none
// ============================================================================
//  Module      : mvm_packet_injector
//  Description : Upstream feeder for mvm_top. Turns raw weight and
//                input-vector word streams into NoC-formatted AXIS packets.
//                Each command emits one RF-write packet (op 2'b11) per RF of
//                every target router, followed by a single input-vector
//                packet (op 2'b10).
//  Ports       :
//    clk, rst               clock / synchronous active-high reset
//    i_start                one-cycle command pulse (sampled in IDLE only)
//    i_cfg_first_dest       first router destination for weight packets
//    i_cfg_num_dest         number of consecutive routers to load
//    i_cfg_num_rf           RFs per router (0..NUM_RF)
//    i_cfg_rf_addr          RF address placed in TUSER[8:0] of weights
//    i_cfg_vec_dest         destination of the input-vector packet
//    i_w_* / o_w_tready     weight word stream (AXIS slave)
//    i_v_* / o_v_tready     input-vector word stream (AXIS slave)
//    o_axis_m_* / i_axis_m_tready  NoC injection port (AXIS master)
//    o_busy                 high from accepted start through the done cycle
//    o_done                 one-cycle pulse after the vector beat retires
//  Revision    : 1.0 - initial release
// ============================================================================
module mvm_packet_injector #(
    parameter int DATAW = 512,
    parameter int DESTW = 12,
    parameter int IDW   = 32,
    parameter int USERW = 75
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [DESTW-1:0] i_cfg_first_dest,
    input  logic [DESTW-1:0] i_cfg_num_dest,
    input  logic [6:0]       i_cfg_num_rf,
    input  logic [8:0]       i_cfg_rf_addr,
    input  logic [DESTW-1:0] i_cfg_vec_dest,
    input  logic             i_w_tvalid,
    output logic             o_w_tready,
    input  logic [DATAW-1:0] i_w_tdata,
    input  logic             i_v_tvalid,
    output logic             o_v_tready,
    input  logic [DATAW-1:0] i_v_tdata,
    output logic             o_axis_m_tvalid,
    input  logic             i_axis_m_tready,
    output logic [DATAW-1:0] o_axis_m_tdata,
    output logic             o_axis_m_tlast,
    output logic [IDW-1:0]   o_axis_m_tid,
    output logic [USERW-1:0] o_axis_m_tuser,
    output logic [DESTW-1:0] o_axis_m_tdest,
    output logic             o_busy,
    output logic             o_done
);

    localparam int NUM_RF = USERW - 11;
    localparam int KW     = $clog2(NUM_RF);

    localparam logic [1:0] c_OP_RF_WRITE = 2'b11;
    localparam logic [1:0] c_OP_VECTOR   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_W = 2'd1,
        S_LOAD_V = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Command configuration latched at start
    logic [DESTW-1:0] r_first_dest;
    logic [DESTW-1:0] r_num_dest;
    logic [6:0]       r_num_rf;
    logic [8:0]       r_rf_addr;
    logic [DESTW-1:0] r_vec_dest;

    // Position within the weight sweep: k = RF lane, d = router offset
    logic [KW-1:0]    r_k;
    logic [DESTW-1:0] r_d;

    // Single-entry output register
    logic             r_tvalid;
    logic [DATAW-1:0] r_tdata;
    logic [USERW-1:0] r_tuser;
    logic [DESTW-1:0] r_tdest;
    logic             r_tlast;
    logic             r_done;

    logic              w_load_en;
    logic              w_start_ok;
    logic              w_skip_w;
    logic              w_w_fire;
    logic              w_v_fire;
    logic              w_last_rf;
    logic              w_last_dest;
    logic              w_w_tready;
    logic              w_v_tready;
    logic [NUM_RF-1:0] w_sel;

    // The output register can take a new beat when empty or retiring now
    assign w_load_en   = !r_tvalid || i_axis_m_tready;
    // A start in the done cycle is still inside the busy window
    assign w_start_ok  = (r_state == S_IDLE) && i_start && !r_done;
    assign w_skip_w    = (i_cfg_num_dest == '0) || (i_cfg_num_rf == 7'd0);
    assign w_w_fire    = (r_state == S_LOAD_W) && w_load_en && i_w_tvalid;
    assign w_v_fire    = (r_state == S_LOAD_V) && w_load_en && i_v_tvalid;
    assign w_last_rf   = (7'(r_k) == (r_num_rf - 7'd1));
    assign w_last_dest = (r_d == (r_num_dest - DESTW'(1)));
    assign w_sel       = NUM_RF'(1) << r_k;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and ready outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_w_tready  = 1'b0;
        w_v_tready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = w_skip_w ? S_LOAD_V : S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                w_w_tready = w_load_en;
                if (w_w_fire && w_last_rf && w_last_dest) begin
                    w_state_nxt = S_LOAD_V;
                end
            end
            S_LOAD_V: begin
                w_v_tready = w_load_en;
                if (w_v_fire) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                // The vector beat is either already gone or retiring now
                if (w_load_en) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Configuration, sweep counters, output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first_dest <= '0;
            r_num_dest   <= '0;
            r_num_rf     <= '0;
            r_rf_addr    <= '0;
            r_vec_dest   <= '0;
            r_k          <= '0;
            r_d          <= '0;
            r_tvalid     <= 1'b0;
            r_tdata      <= '0;
            r_tuser      <= '0;
            r_tdest      <= '0;
            r_tlast      <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIN) && w_load_en;

            if (w_start_ok) begin
                r_first_dest <= i_cfg_first_dest;
                r_num_dest   <= i_cfg_num_dest;
                r_num_rf     <= i_cfg_num_rf;
                r_rf_addr    <= i_cfg_rf_addr;
                r_vec_dest   <= i_cfg_vec_dest;
                r_k          <= '0;
                r_d          <= '0;
            end

            if (w_w_fire) begin
                if (w_last_rf) begin
                    r_k <= '0;
                    r_d <= w_last_dest ? '0 : (r_d + DESTW'(1));
                end else begin
                    r_k <= r_k + KW'(1);
                end
            end

            if (w_load_en) begin
                if (w_w_fire) begin
                    r_tvalid <= 1'b1;
                    r_tdata  <= i_w_tdata;
                    r_tuser  <= {w_sel, c_OP_RF_WRITE, r_rf_addr};
                    r_tdest  <= r_first_dest + r_d;  // wraps mod 2^DESTW
                    r_tlast  <= 1'b1;
                end else if (w_v_fire) begin
                    r_tvalid <= 1'b1;
                    r_tdata  <= i_v_tdata;
                    r_tuser  <= {{NUM_RF{1'b0}}, c_OP_VECTOR, 9'd0};
                    r_tdest  <= r_vec_dest;
                    r_tlast  <= 1'b1;
                end else begin
                    r_tvalid <= 1'b0;
                end
            end
        end
    end

    assign o_w_tready      = w_w_tready;
    assign o_v_tready      = w_v_tready;
    assign o_axis_m_tvalid = r_tvalid;
    assign o_axis_m_tdata  = r_tdata;
    assign o_axis_m_tuser  = r_tuser;
    assign o_axis_m_tdest  = r_tdest;
    assign o_axis_m_tlast  = r_tlast;
    assign o_axis_m_tid    = '0;
    assign o_done          = r_done;
    // Stays high through the done cycle, drops on the following one
    assign o_busy          = (r_state != S_IDLE) || r_done;

endmodule
`default_nettype wire
